shift_add_multiplier: RTL and testbench
=======================================

// Module: shift_add_multiplier
// PURPOSE
//   Sequential 16x16 unsigned multiplier, shift-and-add, one partial product per clock.
//   Drives operands into the team's external 16-bit ripple adder every CALC cycle.
//   Consumes the adder's sum/carry-out and accumulates a 32-bit product.
//   Sits between the ALU operand registers and the result writeback for the MUL opcode.
// PARAMETERS
//   WIDTH  16  operand width; must equal the adder width (only 16 is supported)
// PORTS
//   clk       in   1   rising-edge clock
//   rst_n     in   1   synchronous active-low reset
//   start     in   1   request; sampled only while busy=0
//   op_a      in   16  multiplicand; latched on accepted start
//   op_b      in   16  multiplier; latched on accepted start
//   busy      out  1   high while in CALC
//   done      out  1   single-cycle pulse; product valid
//   product   out  32  {hi,lo} result register; holds until next accepted start
//   add_a     out  16  to adder operand A
//   add_b     out  16  to adder operand B
//   add_sum   in   16  from adder sum
//   add_cout  in   1   from adder carry-out (adder carry-in is 0)
// BEHAVIOUR
//   Reset: one clock; synchronous; active-low.
//   rst_n=0 at a clock edge -> state IDLE; busy=0, done=0, product=0.
//   rst_n=0 also clears M, hi, lo and cnt to 0. It aborts any CALC in progress.
//   State IDLE: busy=0, done=0, product holds.
//   State CALC: busy=1; counter cnt runs 0..15.
//   State DONE: busy=0, done=1 for exactly one cycle.
//   Accept: start=1 and state is IDLE or DONE.
//     On accept: M<=op_a, hi<=0, lo<=op_b, cnt<=0, next state CALC.
//   Start while busy=1 is ignored. No queuing; op_a/op_b changes are also ignored.
//   CALC step, combinational outputs:
//     add_a = hi
//     add_b = lo[0] ? M : 16'h0000
//   CALC step, registered update:
//     {hi,lo} <= {add_cout, add_sum, lo[15:1]}  (33-bit right shift by 1)
//     cnt <= cnt+1
//   In CALC with cnt==15: after the update, next state is DONE.
//   Latency: start edge T0 -> CALC at edges T1..T16 -> done=1 during the cycle after T16.
//     Accept-to-done = 17 cycles. Throughput: 1 result per 17 cycles back-to-back.
//   DONE: start=1 -> accept (CALC next); otherwise -> IDLE.
//   The product register is {hi,lo}. It is visible at all times.
//     Mid-CALC contents are partial and not valid until done.
//   In IDLE/DONE: add_a = hi, add_b = 0. The adder result is unused.
//   Arithmetic is unsigned. add_cout is the 17th accumulator bit; no overflow is possible.
//   No hidden state beyond state, cnt(4b), M, hi, lo.
// TESTING
//   op_a=3, op_b=5, start 1 cycle -> busy for 16 cycles; done pulse at cycle 17; product=32'h0000000F.
//   op_a=16'hFFFF, op_b=16'hFFFF -> product=32'hFFFE0001 (exercises add_cout every step).
//   op_a=16'h1234, op_b=0 -> product=0, done at cycle 17; add_b stays 0 throughout.
//   Second start with 7x9 during CALC of 2x4 -> ignored; product=8; exactly one done.
//   rst_n=0 at CALC cycle 8 -> next cycle busy=0, done=0, product=0.
//     Then 10x10 -> product=100.
//   start held high through DONE (6x7 then 8x8) -> done=1, product=42.
//     Restart same edge; next done 17 cycles later, product=64.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned shift-and-add multiplier using an external ripple adder
module shift_add_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] m, hi, lo;
  logic [CW-1:0] cnt;
  logic accept;
  always_comb begin
    accept  = start && state != CALC;
    state_n = accept ? CALC : IDLE;
    if (state == CALC) state_n = cnt == CW'(WIDTH-1) ? DONE : CALC;
  end
  assign busy    = state == CALC;
  assign done    = state == DONE;
  assign product = {hi, lo};
  assign add_a   = hi;
  assign add_b   = (busy && lo[0]) ? m : '0;
  // carry-out becomes the top accumulator bit as the 33-bit value shifts right
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      m     <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        m   <= op_a;
        hi  <= '0;
        lo  <= op_b;
        cnt <= '0;
      end else if (busy) begin
        {hi, lo} <= {add_cout, add_sum, lo[WIDTH-1:1]};
        cnt      <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed checks of the shift-add multiplier with a behavioural adder
module tb_shift_add_multiplier;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        start = 0;
  logic [15:0] op_a = 0, op_b = 0;
  logic        busy, done, add_cout;
  logic [31:0] product;
  logic [15:0] add_a, add_b, add_sum;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  assign {add_cout, add_sum} = 17'(add_a) + 17'(add_b);
  shift_add_multiplier dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_cout(add_cout)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic mul(input logic [15:0] a, input logic [15:0] b, input bit hold,
                     input logic [31:0] exp, output int lat, output int bsy, output bit nz);
    op_a = a;
    op_b = b;
    start = 1;
    tick();
    if (!hold) start = 0;
    lat = 1;
    bsy = 0;
    nz = 0;
    while (!done && lat < 40) begin
      bsy += int'(busy);
      nz |= add_b != 0;
      tick();
      lat++;
    end
    chk("latency", lat, 17);
    chk("product", product, exp);
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 0);
  endtask
  initial begin
    int lat, bsy, n;
    bit nz;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_product", product, 0);
    chk("rst_add_b", add_b, 0);
    rst_n = 1;
    tick();
    mul(3, 5, 0, 32'h0000000F, lat, bsy, nz);
    chk("busy_cycles", bsy, 16);
    tick();
    chk("done_single", done, 0);
    chk("hold_product", product, 32'h0000000F);
    tick();
    chk("idle_busy", busy, 0);
    mul(16'hFFFF, 16'hFFFF, 0, 32'hFFFE0001, lat, bsy, nz);
    tick();
    mul(16'h1234, 0, 0, 0, lat, bsy, nz);
    chk("addb_zero", 32'(nz), 0);
    tick();
    op_a = 2;
    op_b = 4;
    start = 1;
    tick();
    start = 0;
    repeat (3) tick();
    op_a = 7;
    op_b = 9;
    start = 1;
    tick();
    start = 0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      n += int'(done);
      tick();
    end
    chk("ignored_done_count", n, 1);
    chk("ignored_product", product, 8);
    op_a = 5;
    op_b = 5;
    start = 1;
    tick();
    start = 0;
    repeat (7) tick();
    chk("mid_calc_busy", busy, 1);
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_product", product, 0);
    tick();
    mul(10, 10, 0, 100, lat, bsy, nz);
    tick();
    mul(6, 7, 1, 42, lat, bsy, nz);
    mul(8, 8, 0, 64, lat, bsy, nz);
    tick();
    chk("final_done_low", done, 0);
    chk("final_product", product, 64);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
